// File: rtl/jtag_uart_sample_sequencer_pkg.sv
// jtag_seq_pkg: sequencer states, byte tags and JTAG UART register map (WSPACE state exists only with SEQ_WSPACE_CHECK_EN)
package jtag_seq_pkg;
  localparam logic [2:0] STARTUP = 3'd0;
  localparam logic [2:0] RX = 3'd1;
  localparam logic [2:0] PUSH = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] FETCH = 3'd4;
  localparam logic [2:0] WR_LO = 3'd5;
  localparam logic [2:0] WR_HI = 3'd6;
`ifdef SEQ_WSPACE_CHECK_EN
  localparam logic [2:0] WSPACE = 3'd7;
`endif
  localparam logic [2:0] TAG_LO = 3'b000;
  localparam logic [2:0] TAG_HI = 3'b111;
  localparam int RVALID_BIT = 15;
  localparam logic REG_DATA = 1'b0;
  localparam logic REG_CTRL = 1'b1;
endpackage

// File: rtl/jtag_uart_sample_sequencer_if.sv
// jtag_uart_sample_sequencer_if: Avalon-MM link between the sequencer (master) and the JTAG UART (slave)
interface jtag_uart_sample_sequencer_if;
  logic av_chipselect;
  logic av_address;
  logic av_read_n;
  logic av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata;
  logic av_waitrequest;
  modport master(
    output av_chipselect, av_address, av_read_n, av_write_n, av_writedata,
    input av_readdata, av_waitrequest
  );
  modport slave(
    input av_chipselect, av_address, av_read_n, av_write_n, av_writedata,
    output av_readdata, av_waitrequest
  );
endinterface

// File: rtl/jtag_uart_sample_sequencer_xfer.sv
// avalon_jtag_xfer: single outstanding Avalon transaction, strobes held until waitrequest drops
module avalon_jtag_xfer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        rnw,
  input  logic        addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  jtag_uart_sample_sequencer_if.master av
);
  logic active;
  assign active = !av.av_read_n || !av.av_write_n;
  assign av.av_chipselect = active;
  // the done cycle blocks a restart so a still-high req is not taken as a new request
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      av.av_read_n <= 1'b1;
      av.av_write_n <= 1'b1;
      av.av_address <= 1'b0;
      av.av_writedata <= '0;
      done <= 1'b0;
      rdata <= '0;
    end else begin
      done <= active && !av.av_waitrequest;
      if (active && !av.av_waitrequest) begin
        av.av_read_n <= 1'b1;
        av.av_write_n <= 1'b1;
        rdata <= av.av_readdata;
      end else if (!active && !done && req) begin
        av.av_read_n <= !rnw;
        av.av_write_n <= rnw;
        av.av_address <= addr;
        if (!rnw) av.av_writedata <= wdata;
      end
    end
endmodule

// File: rtl/jtag_uart_sample_sequencer.sv
// jtag_uart_sample_sequencer: DAC code in, ADC samples out over the JTAG UART; SEQ_WSPACE_CHECK_EN polls WSPACE before each data write
module jtag_uart_sample_sequencer
  import jtag_seq_pkg::*;
#(
  parameter int STARTUP_CYCLES = 50,
  parameter int NUM_SAMPLES = 128,
  parameter int ADDR_W = 7,
  parameter int CAPTURE_TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              reset_n,
  jtag_uart_sample_sequencer_if.master av,
  output logic [11:0]       dac_code,
  output logic              dac_push,
  output logic              start_sampling,
  input  logic              capture_done,
  output logic [ADDR_W-1:0] buf_addr,
  input  logic [9:0]        buf_data,
  output logic              busy,
  output logic              timeout_err
);
  logic [2:0] state;
  logic [31:0] cnt;
  logic [5:0] code_lo;
  logic lo_seen, fetch_wait, done, req, rnw, addr;
  logic [9:0] s;
  logic [31:0] wdata, rdata;
  logic [7:0] rx_byte;
  logic unused_rdata;
  assign rx_byte = rdata[7:0];
  assign unused_rdata = ^{rdata[31:16], rdata[14:8]};
`ifdef SEQ_WSPACE_CHECK_EN
  logic hi_next;
  assign req = state inside {RX, WR_LO, WR_HI, WSPACE};
  assign rnw = state inside {RX, WSPACE};
  assign addr = state == WSPACE ? REG_CTRL : REG_DATA;
`else
  assign req = state inside {RX, WR_LO, WR_HI};
  assign rnw = state == RX;
  assign addr = REG_DATA;
`endif
  assign wdata = state == WR_HI ? {24'b0, TAG_HI, s[9:5]} : {24'b0, TAG_LO, s[4:0]};
  assign busy = state != RX;
  avalon_jtag_xfer u_xfer (
    .clk(clk), .reset_n(reset_n), .req(req), .rnw(rnw), .addr(addr),
    .wdata(wdata), .done(done), .rdata(rdata), .av(av)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= STARTUP;
      cnt <= '0;
      code_lo <= '0;
      lo_seen <= 1'b0;
      fetch_wait <= 1'b0;
      s <= '0;
      dac_code <= '0;
      dac_push <= 1'b0;
      start_sampling <= 1'b0;
      buf_addr <= '0;
      timeout_err <= 1'b0;
`ifdef SEQ_WSPACE_CHECK_EN
      hi_next <= 1'b0;
`endif
    end else begin
      dac_push <= 1'b0;
      start_sampling <= 1'b0;
      case (state)
        STARTUP: begin
          cnt <= cnt + 32'd1;
          state <= cnt == 32'(STARTUP_CYCLES - 1) ? RX : STARTUP;
        end
        RX: if (done && rdata[RVALID_BIT]) begin
          if (!rx_byte[7]) begin
            code_lo <= rx_byte[5:0];
            lo_seen <= 1'b1;
          end else if (lo_seen) begin
            dac_code <= {rx_byte[5:0], code_lo};
            dac_push <= 1'b1;
            start_sampling <= 1'b1;
            state <= PUSH;
          end
        end
        PUSH: begin
          lo_seen <= 1'b0;
          timeout_err <= 1'b0;
          cnt <= '0;
          state <= CAPTURE;
        end
        CAPTURE: if (capture_done) begin
          buf_addr <= '0;
          state <= FETCH;
        end else if (cnt == 32'(CAPTURE_TIMEOUT - 1)) begin
          timeout_err <= 1'b1;
          state <= RX;
        end else cnt <= cnt + 32'd1;
        // first cycle lets the registered buffer read settle
        FETCH: begin
          fetch_wait <= !fetch_wait;
          if (fetch_wait) begin
            s <= buf_data;
`ifdef SEQ_WSPACE_CHECK_EN
            hi_next <= 1'b0;
            state <= WSPACE;
`else
            state <= WR_LO;
`endif
          end
        end
        WR_LO: if (done) begin
`ifdef SEQ_WSPACE_CHECK_EN
          hi_next <= 1'b1;
          state <= WSPACE;
`else
          state <= WR_HI;
`endif
        end
        WR_HI: if (done) begin
          if (buf_addr == ADDR_W'(NUM_SAMPLES - 1)) state <= RX;
          else begin
            buf_addr <= buf_addr + ADDR_W'(1);
            state <= FETCH;
          end
        end
`ifdef SEQ_WSPACE_CHECK_EN
        WSPACE: if (done && |rdata[31:16]) state <= hi_next ? WR_HI : WR_LO;
`endif
        default: state <= STARTUP;
      endcase
    end
endmodule
